uart_tx_fifo_core: RTL and testbench

UART_TX_FIFO_CORE -- requirements
Module: uart_tx_fifo_core

---
 rtl/uart_tx_pkg.sv | 17 +
 rtl/uart_tx_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo_core.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_fifo_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmitter: frame FSM states and FIFO level sizing.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   // Level must represent 0..depth inclusive, hence one bit beyond the pointer width.
   function automatic int level_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit buffer: register-array FIFO with registered full/empty/level flags.
module uart_tx_fifo
   import uart_tx_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [WIDTH-1:0]              wr_data,
   input  logic                          wr_en,
   input  logic                          rd_en,
   output logic [WIDTH-1:0]              rd_data,
   output logic                          full,
   output logic                          empty,
   output logic [level_width(DEPTH)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;
   logic [LW-1:0]    level_nxt;

   assign push    = wr_en && !full;
   assign pop     = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_comb begin
      level_nxt = level;
      if (push && !pop) begin
         level_nxt = level + LW'(1);
      end else if (pop && !push) begin
         level_nxt = level - LW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_nxt;
         full  <= (level_nxt == LW'(DEPTH));
         empty <= (level_nxt == '0);
      end
   end

   // Data contents carry no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

// File: rtl/uart_tx_fifo_core.sv
// Buffered UART transmitter: FIFO feeding a start/data/parity/stop frame FSM.
//
// state     | meaning
// ST_IDLE   | line high, waiting for a queued character
// ST_START  | start bit, tx low
// ST_DATA   | data bits, LSB first
// ST_PARITY | optional parity bit
// ST_STOP   | one or two stop bits, tx high
module uart_tx_fifo_core
   import uart_tx_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [DATA_BITS-1:0]               data_in,
   input  logic                               wr_en,
   input  logic                               parity_en,
   input  logic                               parity_odd,
   input  logic                               two_stop,
   input  logic                               clr_ovf,
   output logic                               full,
   output logic                               empty,
   output logic [level_width(FIFO_DEPTH)-1:0] level,
   output logic                               overflow,
   output logic                               busy,
   output logic                               tx
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);

   tx_state_t            state;
   logic [BW-1:0]        baud;
   logic [CW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] head;
   logic                 parity_bit_q;
   logic                 parity_en_q;
   logic                 two_stop_q;
   logic                 baud_wrap;
   logic                 frame_end;
   logic                 pop;

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_data (data_in),
      .wr_en   (wr_en),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign baud_wrap = (baud == BAUD_LAST);
   // In STOP, bit_cnt marks the second stop bit when two stop bits are latched.
   assign frame_end = (state == ST_STOP) && baud_wrap && (!two_stop_q || (bit_cnt != '0));
   assign pop       = !empty && ((state == ST_IDLE) || frame_end);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         baud         <= '0;
         bit_cnt      <= '0;
         shift_q      <= '0;
         parity_bit_q <= 1'b0;
         parity_en_q  <= 1'b0;
         two_stop_q   <= 1'b0;
         busy         <= 1'b0;
         tx           <= 1'b1;
      end else if (pop) begin
         // Frame settings are captured here so mid-frame changes wait for the next character.
         state        <= ST_START;
         baud         <= '0;
         bit_cnt      <= '0;
         shift_q      <= head;
         parity_bit_q <= (^head) ^ parity_odd;
         parity_en_q  <= parity_en;
         two_stop_q   <= two_stop;
         busy         <= 1'b1;
         tx           <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               busy <= 1'b0;
               tx   <= 1'b1;
            end
            ST_START: begin
               if (baud_wrap) begin
                  state   <= ST_DATA;
                  baud    <= '0;
                  bit_cnt <= '0;
                  tx      <= shift_q[0];
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            ST_DATA: begin
               if (baud_wrap) begin
                  baud <= '0;
                  if (bit_cnt == BIT_LAST) begin
                     bit_cnt <= '0;
                     if (parity_en_q) begin
                        state <= ST_PARITY;
                        tx    <= parity_bit_q;
                     end else begin
                        state <= ST_STOP;
                        tx    <= 1'b1;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                     shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                     tx      <= shift_q[1];
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            ST_PARITY: begin
               if (baud_wrap) begin
                  state   <= ST_STOP;
                  baud    <= '0;
                  bit_cnt <= '0;
                  tx      <= 1'b1;
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            ST_STOP: begin
               if (frame_end) begin
                  state   <= ST_IDLE;
                  baud    <= '0;
                  bit_cnt <= '0;
                  busy    <= 1'b0;
                  tx      <= 1'b1;
               end else if (baud_wrap) begin
                  baud    <= '0;
                  bit_cnt <= CW'(1);
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_core.sv
// Directed bench for uart_tx_fifo_core: 8-bit and 5-bit instances, 4 clk per bit, depth 4.
module tb_uart_tx_fifo_core;

   logic       clk;
   logic       reset_n;
   logic [7:0] d8;
   logic [4:0] d5;
   logic       wr8;
   logic       wr5;
   logic       parity_en;
   logic       parity_odd;
   logic       two_stop;
   logic       clr_ovf;

   logic       full8, empty8, overflow8, busy8, tx8;
   logic [2:0] level8;
   logic       full5, empty5, overflow5, busy5, tx5;
   logic [2:0] level5;

   int total = 0;
   int bad   = 0;
   int bcnt;
   int lowcnt;
   int busycnt;

   uart_tx_fifo_core #(
      .DATA_BITS    (8),
      .FIFO_DEPTH   (4),
      .CLKS_PER_BIT (4)
   ) dut8 (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (d8),
      .wr_en      (wr8),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .two_stop   (two_stop),
      .clr_ovf    (clr_ovf),
      .full       (full8),
      .empty      (empty8),
      .level      (level8),
      .overflow   (overflow8),
      .busy       (busy8),
      .tx         (tx8)
   );

   uart_tx_fifo_core #(
      .DATA_BITS    (5),
      .FIFO_DEPTH   (4),
      .CLKS_PER_BIT (4)
   ) dut5 (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (d5),
      .wr_en      (wr5),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .two_stop   (two_stop),
      .clr_ovf    (clr_ovf),
      .full       (full5),
      .empty      (empty5),
      .level      (level5),
      .overflow   (overflow5),
      .busy       (busy5),
      .tx         (tx5)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // exp holds the line level of each bit period in transmit order; every bit is sampled 4 times.
   task automatic run_frame(input string tag, input string exp, input bit use5,
                            input bit find_start, input int first_bit, output int busy_cnt);
      logic [3:0] obs;
      logic       e;
      busy_cnt = 0;
      if (find_start) begin
         for (int i = 0; i < 40; i++) begin
            if ((use5 ? tx5 : tx8) === 1'b0) break;
            @(negedge clk);
         end
         check({tag, "_start_seen"}, 32'(use5 ? tx5 : tx8), 32'd0);
      end
      for (int b = first_bit; b < exp.len(); b++) begin
         e = (exp[b] == "1");
         for (int c = 0; c < 4; c++) begin
            obs[c] = use5 ? tx5 : tx8;
            if ((use5 ? busy5 : busy8) === 1'b1) busy_cnt++;
            @(negedge clk);
         end
         check($sformatf("%s_bit%0d", tag, b), 32'(obs), 32'({4{e}}));
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      d8         = '0;
      d5         = '0;
      wr8        = 1'b0;
      wr5        = 1'b0;
      parity_en  = 1'b1;
      parity_odd = 1'b0;
      two_stop   = 1'b0;
      clr_ovf    = 1'b0;

      // Reset state
      tick(3);
      check("rst_tx", 32'(tx8), 32'd1);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_level", 32'(level8), 32'd0);
      check("rst_empty", 32'(empty8), 32'd1);
      check("rst_full", 32'(full8), 32'd0);
      check("rst_ovf", 32'(overflow8), 32'd0);
      check("rst_tx5", 32'(tx5), 32'd1);

      // Release with a write in the same cycle; 0x55, 8E1
      reset_n = 1'b1;
      wr8     = 1'b1;
      d8      = 8'h55;
      tick(1);
      wr8 = 1'b0;
      check("a_level", 32'(level8), 32'd1);
      check("a_empty", 32'(empty8), 32'd0);
      check("a_busy_pre", 32'(busy8), 32'd0);
      run_frame("a", "01010101001", 1'b0, 1'b1, 0, bcnt);
      check("a_busy_len", 32'(bcnt), 32'd44);
      check("a_busy_post", 32'(busy8), 32'd0);
      check("a_tx_idle", 32'(tx8), 32'd1);

      // Odd parity, two stop bits, back-to-back 0x00 and 0x01
      parity_en  = 1'b1;
      parity_odd = 1'b1;
      two_stop   = 1'b1;
      wr8 = 1'b1;
      d8  = 8'h00;
      tick(1);
      d8 = 8'h01;
      tick(1);
      wr8 = 1'b0;
      run_frame("b0", "000000000111", 1'b0, 1'b1, 0, bcnt);
      run_frame("b1", "010000000011", 1'b0, 1'b0, 0, bcnt);
      check("b_busy_post", 32'(busy8), 32'd0);

      // Six consecutive writes into depth 4; drop coincides with clr_ovf
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      two_stop   = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) begin
            check("c_start_tx", 32'(tx8), 32'd0);
            check("c_start_busy", 32'(busy8), 32'd1);
         end
         wr8     = 1'b1;
         d8      = 8'(8'h11 * (i + 1));
         clr_ovf = (i == 5);
         tick(1);
      end
      wr8     = 1'b0;
      clr_ovf = 1'b0;
      check("c_level_full", 32'(level8), 32'd4);
      check("c_full", 32'(full8), 32'd1);
      check("c_ovf_set", 32'(overflow8), 32'd1);
      run_frame("c1", "0100010001", 1'b0, 1'b0, 1, bcnt);
      run_frame("c2", "0010001001", 1'b0, 1'b0, 0, bcnt);
      run_frame("c3", "0110011001", 1'b0, 1'b0, 0, bcnt);
      run_frame("c4", "0001000101", 1'b0, 1'b0, 0, bcnt);
      run_frame("c5", "0101010101", 1'b0, 1'b0, 0, bcnt);
      check("c_busy_post", 32'(busy8), 32'd0);
      check("c_level_post", 32'(level8), 32'd0);
      check("c_empty_post", 32'(empty8), 32'd1);
      check("c_ovf_sticky", 32'(overflow8), 32'd1);
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      check("c_ovf_clr", 32'(overflow8), 32'd0);

      // parity_en raised mid-frame: frame 1 stays 8N1, frame 2 picks up even parity
      wr8 = 1'b1;
      d8  = 8'h55;
      tick(1);
      d8 = 8'h07;
      tick(1);
      wr8 = 1'b0;
      parity_en = 1'b1;
      run_frame("f1", "0101010101", 1'b0, 1'b1, 0, bcnt);
      run_frame("f2", "01110000011", 1'b0, 1'b0, 0, bcnt);
      check("f_busy_post", 32'(busy8), 32'd0);

      // 5-bit characters, no parity
      parity_en = 1'b0;
      two_stop  = 1'b0;
      wr5 = 1'b1;
      d5  = 5'h1F;
      tick(1);
      wr5 = 1'b0;
      run_frame("d", "0111111", 1'b1, 1'b1, 0, bcnt);
      check("d_busy_len", 32'(bcnt), 32'd28);
      check("d_busy_post", 32'(busy5), 32'd0);

      // Reset during DATA with three characters queued
      for (int i = 0; i < 4; i++) begin
         wr8 = 1'b1;
         d8  = 8'(8'h81 + i);
         tick(1);
      end
      wr8 = 1'b0;
      check("e_level_q", 32'(level8), 32'd3);
      tick(6);
      check("e_tx_data", 32'(tx8), 32'd0);
      reset_n = 1'b0;
      #1;
      check("e_rst_tx", 32'(tx8), 32'd1);
      check("e_rst_level", 32'(level8), 32'd0);
      check("e_rst_busy", 32'(busy8), 32'd0);
      check("e_rst_empty", 32'(empty8), 32'd1);
      tick(2);
      reset_n = 1'b1;
      lowcnt  = 0;
      busycnt = 0;
      for (int i = 0; i < 60; i++) begin
         tick(1);
         if (tx8 !== 1'b1) lowcnt++;
         if (busy8 !== 1'b0) busycnt++;
      end
      check("e_no_frame_tx", 32'(lowcnt), 32'd0);
      check("e_no_frame_busy", 32'(busycnt), 32'd0);
      check("e_level_after", 32'(level8), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
